// File: rtl/pulse_width_decoder_if.sv
// Pulse-width decoder bus: the raw pulse line in, the decoded result out.
// The decoder takes the master side; whoever drives pin and consumes results takes the slave side.
interface pulse_width_decoder_if;
   logic       pin;
   logic [8:0] width;
   logic       valid;
   logic       err;
   logic       busy;

   modport master (
      input  pin,
      output width,
      output valid,
      output err,
      output busy
   );

   modport slave (
      output pin,
      input  width,
      input  valid,
      input  err,
      input  busy
   );
endinterface

// File: rtl/pulse_width_decoder.sv
// Measures the high time of an asynchronous pulse line in divider ticks and reports it
// as a 9-bit width with a one-cycle valid strobe; pulses past 511 ticks flag err.
module pulse_width_decoder #(
   parameter int DIV_WIDTH = 15,
   parameter int DIV_COUNT = 5207,
   parameter int MIN_TICKS = 4
) (
   input logic                   sysclk,
   input logic                   rst_n,
   pulse_width_decoder_if.master bus
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_COUNT);
   localparam logic [8:0]           MIN_CNT  = 9'(MIN_TICKS);
   localparam logic [8:0]           CNT_MAX  = 9'd511;

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      OVERRUN
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 sync_a;
   logic                 sync_b;
   logic                 pin_prev;
   logic                 rise;
   logic [DIV_WIDTH-1:0] div;
   logic [DIV_WIDTH-1:0] div_cur;
   logic                 tick;
   logic [8:0]           count;
   logic [8:0]           count_nxt;
   logic [8:0]           width_q;
   logic [8:0]           width_nxt;
   logic                 err_q;
   logic                 err_nxt;
   logic                 valid_q;
   logic                 valid_nxt;

   // Reset to 1 so a line already high when reset releases never looks like a start edge.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a   <= 1'b1;
         sync_b   <= 1'b1;
         pin_prev <= 1'b1;
      end else begin
         sync_a   <= bus.pin;
         sync_b   <= sync_a;
         pin_prev <= sync_b;
      end
   end

   assign rise = sync_b & ~pin_prev;

   // The divider reads 0 in the start-edge cycle itself, so N full tick periods of high
   // level produce exactly N ticks before the falling edge is seen.
   assign div_cur = rise ? '0 : div;
   assign tick    = (div_cur == DIV_LAST);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div_cur + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         count   <= 9'd0;
         width_q <= 9'd0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         width_q <= width_nxt;
         err_q   <= err_nxt;
         valid_q <= valid_nxt;
      end
   end

   // A low line is checked before the tick, so a coinciding tick is never counted.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      width_nxt = width_q;
      err_nxt   = err_q;
      valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = MEASURE;
               count_nxt = 9'd0;
            end
         end
         MEASURE: begin
            if (!sync_b) begin
               state_nxt = IDLE;
               if (count >= MIN_CNT) begin
                  width_nxt = count;
                  err_nxt   = 1'b0;
                  valid_nxt = 1'b1;
               end
            end else if (tick) begin
               if (count == CNT_MAX) begin
                  state_nxt = OVERRUN;
               end else begin
                  count_nxt = count + 9'd1;
               end
            end
         end
         OVERRUN: begin
            if (!sync_b) begin
               state_nxt = IDLE;
               width_nxt = CNT_MAX;
               err_nxt   = 1'b1;
               valid_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.width = width_q;
   assign bus.err   = err_q;
   assign bus.valid = valid_q;
   assign bus.busy  = (state != IDLE);

endmodule
